// File: rtl/f1_start_sequencer.sv
// F1 start-light sequencer: lights eight lamps one per tick, holds them for a
// pseudo-random number of ticks, blanks them and times the player's reaction.
// Also contains its own tick divider and a 7-bit LFSR. A button edge before
// lights-out is reported as a jump start.
module f1_start_sequencer #(
    parameter int WIDTH   = 16,
    parameter int REACT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               trigger,
    input  logic               button,
    input  logic [WIDTH-1:0]   N,
    input  logic [WIDTH-1:0]   K_MIN,
    output logic [7:0]         data_out,
    output logic               busy,
    output logic [WIDTH-1:0]   rand_delay,
    output logic [REACT_W-1:0] react_time,
    output logic               react_valid,
    output logic               jump_start,
    output logic               overflow
);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_ARM         = 3'd1,
        S_HOLD        = 3'd2,
        S_MEASURE     = 3'd3,
        S_DONE        = 3'd4,
        S_FALSE_START = 3'd5
    } state_t;

    localparam logic [WIDTH-1:0]   ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [REACT_W-1:0] ONE_R   = {{(REACT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   ZERO_W  = {WIDTH{1'b0}};
    localparam logic [REACT_W-1:0] ZERO_R  = {REACT_W{1'b0}};
    localparam logic [REACT_W-1:0] MAX_R   = {REACT_W{1'b1}};
    localparam logic [7:0]         LAMPS_ALL   = 8'hFF;
    localparam logic [7:0]         LAMPS_FIRST = 8'h01;
    localparam logic [7:0]         LAMPS_FALSE = 8'hAA;
    localparam logic [7:0]         LAMPS_OFF   = 8'h00;

    // Shift left, feed back taps 6 and 2.
    function automatic logic [6:0] lfsr_next(input logic [6:0] cur);
        return {cur[5:0], cur[6] ^ cur[2]};
    endfunction

    // K_MIN plus the zero-extended LFSR value, clamped at all-ones.
    function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a,
                                                 input logic [6:0]       b);
        logic [WIDTH:0] sum;
        sum = {1'b0, a} + {{(WIDTH-6){1'b0}}, b};
        if (sum[WIDTH]) begin
            return {WIDTH{1'b1}};
        end else begin
            return sum[WIDTH-1:0];
        end
    endfunction

    state_t               state_q, state_d;
    logic                 trig_q, btn_q;
    logic [6:0]           lfsr_q;
    logic [WIDTH-1:0]     div_q, div_d;
    logic [WIDTH-1:0]     hold_q, hold_d;
    logic [REACT_W-1:0]   react_cnt_q, react_cnt_d;
    logic [7:0]           data_out_q, data_out_d;
    logic [WIDTH-1:0]     rand_delay_q, rand_delay_d;
    logic [REACT_W-1:0]   react_time_q, react_time_d;
    logic                 react_valid_q, react_valid_d;
    logic                 jump_q, jump_d;
    logic                 ovf_q, ovf_d;
    logic                 busy_q, busy_d;

    logic                 trig_e, btn_e, tick, react_max, lamps_full;
    logic [WIDTH-1:0]     hold_load;

    assign trig_e     = trigger & ~trig_q;
    assign btn_e      = button & ~btn_q;
    assign tick       = ((state_q == S_ARM) || (state_q == S_HOLD)) && (div_q == ZERO_W);
    assign react_max  = (react_cnt_q == MAX_R);
    assign lamps_full = (data_out_q == LAMPS_ALL);
    assign hold_load  = sat_add(K_MIN, lfsr_q);

    assign data_out    = data_out_q;
    assign busy        = busy_q;
    assign rand_delay  = rand_delay_q;
    assign react_time  = react_time_q;
    assign react_valid = react_valid_q;
    assign jump_start  = jump_q;
    assign overflow    = ovf_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decision; a button edge outranks any tick in ARM/HOLD.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_FALSE_START: begin
                if (trig_e) begin
                    state_d = S_ARM;
                end else begin
                    state_d = state_q;
                end
            end
            S_ARM: begin
                if (btn_e) begin
                    state_d = S_FALSE_START;
                end else if (tick && lamps_full) begin
                    state_d = S_HOLD;
                end else begin
                    state_d = S_ARM;
                end
            end
            S_HOLD: begin
                if (btn_e) begin
                    state_d = S_FALSE_START;
                end else if (tick && (hold_q == ZERO_W)) begin
                    state_d = S_MEASURE;
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_MEASURE: begin
                if (btn_e || react_max) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_MEASURE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output and datapath next values for the current state.
    always_comb begin
        div_d         = div_q;
        hold_d        = hold_q;
        react_cnt_d   = react_cnt_q;
        data_out_d    = data_out_q;
        rand_delay_d  = rand_delay_q;
        react_time_d  = react_time_q;
        react_valid_d = 1'b0;
        jump_d        = jump_q;
        ovf_d         = ovf_q;
        busy_d        = (state_d == S_ARM) || (state_d == S_HOLD) || (state_d == S_MEASURE);

        // The divider only runs while lamps are being sequenced or held.
        if ((state_q == S_ARM) || (state_q == S_HOLD)) begin
            if (div_q == ZERO_W) begin
                div_d = N;
            end else begin
                div_d = div_q - ONE_W;
            end
        end else begin
            div_d = div_q;
        end

        case (state_q)
            S_IDLE, S_DONE, S_FALSE_START: begin
                if (trig_e) begin
                    div_d        = N;
                    data_out_d   = LAMPS_FIRST;
                    react_time_d = ZERO_R;
                    jump_d       = 1'b0;
                    ovf_d        = 1'b0;
                end else begin
                    data_out_d   = data_out_q;
                end
            end
            S_ARM: begin
                if (btn_e) begin
                    data_out_d = LAMPS_FALSE;
                    jump_d     = 1'b1;
                end else if (tick && !lamps_full) begin
                    data_out_d = {data_out_q[6:0], 1'b1};
                end else if (tick) begin
                    hold_d       = hold_load;
                    rand_delay_d = hold_load;
                end else begin
                    data_out_d = data_out_q;
                end
            end
            S_HOLD: begin
                if (btn_e) begin
                    data_out_d = LAMPS_FALSE;
                    jump_d     = 1'b1;
                end else if (tick && (hold_q == ZERO_W)) begin
                    data_out_d  = LAMPS_OFF;
                    react_cnt_d = ZERO_R;
                end else if (tick) begin
                    hold_d = hold_q - ONE_W;
                end else begin
                    hold_d = hold_q;
                end
            end
            S_MEASURE: begin
                if (react_max) begin
                    react_cnt_d = react_cnt_q;
                end else begin
                    react_cnt_d = react_cnt_q + ONE_R;
                end
                if (btn_e) begin
                    react_time_d  = react_cnt_q;
                    react_valid_d = 1'b1;
                end else if (react_max) begin
                    react_time_d  = MAX_R;
                    ovf_d         = 1'b1;
                    react_valid_d = 1'b1;
                end else begin
                    react_time_d  = react_time_q;
                end
            end
            default: begin
                data_out_d = LAMPS_OFF;
            end
        endcase
    end

    // Datapath, edge-detect and LFSR registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            trig_q        <= 1'b0;
            btn_q         <= 1'b0;
            lfsr_q        <= 7'h01;
            div_q         <= ZERO_W;
            hold_q        <= ZERO_W;
            react_cnt_q   <= ZERO_R;
            data_out_q    <= LAMPS_OFF;
            rand_delay_q  <= ZERO_W;
            react_time_q  <= ZERO_R;
            react_valid_q <= 1'b0;
            jump_q        <= 1'b0;
            ovf_q         <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            trig_q        <= trigger;
            btn_q         <= button;
            lfsr_q        <= lfsr_next(lfsr_q);
            div_q         <= div_d;
            hold_q        <= hold_d;
            react_cnt_q   <= react_cnt_d;
            data_out_q    <= data_out_d;
            rand_delay_q  <= rand_delay_d;
            react_time_q  <= react_time_d;
            react_valid_q <= react_valid_d;
            jump_q        <= jump_d;
            ovf_q         <= ovf_d;
            busy_q        <= busy_d;
        end
    end

endmodule

// File: tb/tb_f1_start_sequencer.sv
// Directed bench for f1_start_sequencer. A narrow reaction counter keeps the
// saturation run short; a reference LFSR predicts rand_delay.
module tb_f1_start_sequencer;

    localparam int WIDTH   = 16;
    localparam int REACT_W = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               trigger;
    logic               button;
    logic [WIDTH-1:0]   N;
    logic [WIDTH-1:0]   K_MIN;
    logic [7:0]         data_out;
    logic               busy;
    logic [WIDTH-1:0]   rand_delay;
    logic [REACT_W-1:0] react_time;
    logic               react_valid;
    logic               jump_start;
    logic               overflow;

    int err_cnt = 0;
    int chk_cnt = 0;

    logic [6:0]       m_lfsr;
    logic [WIDTH-1:0] exp_rd;

    f1_start_sequencer #(.WIDTH(WIDTH), .REACT_W(REACT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .trigger    (trigger),
        .button     (button),
        .N          (N),
        .K_MIN      (K_MIN),
        .data_out   (data_out),
        .busy       (busy),
        .rand_delay (rand_delay),
        .react_time (react_time),
        .react_valid(react_valid),
        .jump_start (jump_start),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Reference LFSR.
    always @(posedge clk) begin
        if (rst) begin
            m_lfsr <= 7'h01;
        end else begin
            m_lfsr <= {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[2]};
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        trigger = 1'b1;
        step();
        trigger = 1'b0;
    endtask

    function automatic logic [7:0] lamp(input int j);
        logic [8:0] t;
        int jj;
        jj = (j > 7) ? 7 : j;
        t = (9'd1 << (jj + 1)) - 9'd1;
        return t[7:0];
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with random inputs
        rst = 1'b1;
        trigger = 1'($urandom_range(0, 1));
        button  = 1'($urandom_range(0, 1));
        N       = 16'($urandom);
        K_MIN   = 16'($urandom);
        step();
        trigger = 1'($urandom_range(0, 1));
        button  = 1'($urandom_range(0, 1));
        step();
        check_val("rst_data_out", 32'(data_out), 32'h0);
        check_val("rst_busy", 32'(busy), 32'h0);
        check_val("rst_rand_delay", 32'(rand_delay), 32'h0);
        check_val("rst_react_time", 32'(react_time), 32'h0);
        check_val("rst_react_valid", 32'(react_valid), 32'h0);
        check_val("rst_jump", 32'(jump_start), 32'h0);
        check_val("rst_overflow", 32'(overflow), 32'h0);
        rst = 1'b0;
        trigger = 1'b0;
        button = 1'b0;
        N = 16'd0;
        K_MIN = 16'd2;
        step();
        check_val("idle_data_out", 32'(data_out), 32'h0);
        check_val("idle_busy", 32'(busy), 32'h0);

        // Normal run, N=0, K_MIN=2
        start_run();
        check_val("n0_first_lamp", 32'(data_out), 32'h01);
        check_val("n0_busy_arm", 32'(busy), 32'h1);
        for (int k = 1; k <= 7; k++) begin
            step();
            check_val("n0_lamp", 32'(data_out), 32'(lamp(k)));
        end
        exp_rd = 16'(K_MIN + 16'(m_lfsr));
        step();
        check_val("n0_rand_delay", 32'(rand_delay), 32'(exp_rd));
        for (int i = 0; i < int'(exp_rd); i++) step();
        check_val("n0_hold_lamps", 32'(data_out), 32'hFF);
        step();
        check_val("n0_lights_out", 32'(data_out), 32'h00);
        check_val("n0_busy_measure", 32'(busy), 32'h1);
        step();
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        check_val("trig_in_measure_data", 32'(data_out), 32'h00);
        check_val("trig_in_measure_busy", 32'(busy), 32'h1);
        step();
        step();
        step();
        button = 1'b1;
        step();
        check_val("n0_react_valid", 32'(react_valid), 32'h1);
        check_val("n0_react_time", 32'(react_time), 32'h5);
        check_val("n0_busy_done", 32'(busy), 32'h0);
        check_val("n0_overflow", 32'(overflow), 32'h0);
        step();
        check_val("n0_valid_one_cycle", 32'(react_valid), 32'h0);
        check_val("n0_react_held", 32'(react_time), 32'h5);
        button = 1'b0;
        step();
        button = 1'b1;
        step();
        button = 1'b0;
        check_val("done_btn_ignored_time", 32'(react_time), 32'h5);
        check_val("done_btn_ignored_jump", 32'(jump_start), 32'h0);
        check_val("done_btn_ignored_valid", 32'(react_valid), 32'h0);

        // N=3 with a false start at 8'h07
        N = 16'd3;
        start_run();
        check_val("n3_first_lamp", 32'(data_out), 32'h01);
        for (int k = 1; k <= 8; k++) begin
            step();
            check_val("n3_lamp_period", 32'(data_out), 32'(lamp(k / 4)));
        end
        button = 1'b1;
        step();
        button = 1'b0;
        check_val("fs_data_out", 32'(data_out), 32'hAA);
        check_val("fs_jump", 32'(jump_start), 32'h1);
        check_val("fs_busy", 32'(busy), 32'h0);
        check_val("fs_valid", 32'(react_valid), 32'h0);
        step();
        check_val("fs_valid_later", 32'(react_valid), 32'h0);
        check_val("fs_held", 32'(data_out), 32'hAA);

        // Restart clears jump start; full N=3 run with HOLD timing
        K_MIN = 16'd1;
        start_run();
        check_val("restart_jump", 32'(jump_start), 32'h0);
        check_val("restart_data", 32'(data_out), 32'h01);
        for (int k = 1; k <= 31; k++) begin
            step();
            check_val("n3_lamp_seq", 32'(data_out), 32'(lamp(k / 4)));
        end
        exp_rd = 16'(K_MIN + 16'(m_lfsr));
        step();
        check_val("n3_rand_delay", 32'(rand_delay), 32'(exp_rd));
        for (int i = 0; i < 4 * (int'(exp_rd) + 1) - 1; i++) step();
        check_val("n3_hold_end_lamps", 32'(data_out), 32'hFF);
        check_val("n3_hold_end_busy", 32'(busy), 32'h1);
        step();
        check_val("n3_lights_out", 32'(data_out), 32'h00);
        button = 1'b1;
        step();
        button = 1'b0;
        check_val("n3_react_zero", 32'(react_time), 32'h0);
        check_val("n3_react_valid", 32'(react_valid), 32'h1);

        // Button edge on the HOLD->MEASURE tick
        N = 16'd0;
        K_MIN = 16'd0;
        start_run();
        for (int k = 1; k <= 7; k++) step();
        exp_rd = 16'(m_lfsr);
        step();
        check_val("edge_rand_delay", 32'(rand_delay), 32'(exp_rd));
        for (int i = 0; i < int'(exp_rd); i++) step();
        button = 1'b1;
        step();
        button = 1'b0;
        check_val("edge_fs_data", 32'(data_out), 32'hAA);
        check_val("edge_fs_jump", 32'(jump_start), 32'h1);
        check_val("edge_fs_valid", 32'(react_valid), 32'h0);

        // Reaction counter saturation
        start_run();
        for (int k = 1; k <= 7; k++) step();
        exp_rd = 16'(m_lfsr);
        step();
        for (int i = 0; i < int'(exp_rd); i++) step();
        step();
        check_val("ovf_lights_out", 32'(data_out), 32'h00);
        check_val("ovf_jump_cleared", 32'(jump_start), 32'h0);
        for (int i = 0; i < 15; i++) step();
        check_val("ovf_not_yet_valid", 32'(react_valid), 32'h0);
        check_val("ovf_not_yet_busy", 32'(busy), 32'h1);
        step();
        check_val("ovf_valid", 32'(react_valid), 32'h1);
        check_val("ovf_time", 32'(react_time), 32'hF);
        check_val("ovf_flag", 32'(overflow), 32'h1);
        check_val("ovf_busy", 32'(busy), 32'h0);
        step();
        check_val("ovf_valid_once", 32'(react_valid), 32'h0);
        check_val("ovf_flag_held", 32'(overflow), 32'h1);

        // Saturating hold load, then reset mid-HOLD
        K_MIN = 16'hFFFF;
        start_run();
        check_val("restart_ovf_clear", 32'(overflow), 32'h0);
        for (int k = 1; k <= 7; k++) step();
        step();
        check_val("sat_rand_delay", 32'(rand_delay), 32'hFFFF);
        step();
        step();
        step();
        check_val("mid_hold_lamps", 32'(data_out), 32'hFF);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("mid_rst_data", 32'(data_out), 32'h00);
        check_val("mid_rst_busy", 32'(busy), 32'h0);
        check_val("mid_rst_rand_delay", 32'(rand_delay), 32'h0);
        step();
        check_val("post_rst_idle", 32'(data_out), 32'h00);
        check_val("post_rst_busy", 32'(busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
